load_store_unit: RTL and testbench

// - MEM-stage initiator for the word-organised data memory: accepts one load/store from the pipeline, issues word requests with byte strobes.
// - Loads: extracts the addressed byte/half/word, sign- or zero-extends it, returns the result with a response pulse.
// - Splits word-crossing misaligned LH/LW/SH/SW into two sequential word accesses.
// - Pipeline stalls on req_ready=0.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/load_store_unit.sv | 205 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings, FSM state type and lane helpers for the load/store unit
// Contents:
//   F3_*           RV32I load/store funct3 encodings
//   lsu_state_t    load_store_unit FSM state
//   size_mask()    funct3[1:0] -> byte-enable mask before lane shifting
//   funct3_legal() access-type / funct3 legality check
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_t;

  // funct3[1:0] encodes the size for both loads and stores (0=B, 1=H, 2=W).
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Exactly one of is_load/is_store must be set, and funct3 must be a defined encoding.
  function automatic logic funct3_legal(input logic is_load, input logic is_store,
                                        input logic [2:0] f3);
    if (is_load == is_store) return 1'b0;
    if (is_load)
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and extends load data from one or two memory words
// Ports:
//   hi      in  32  second word of a split load (0 for single-word loads)
//   lo      in  32  first word
//   off     in  2   byte offset of the access within the first word
//   funct3  in  3   load funct3 (LB/LH/LW/LBU/LHU)
//   result  out 32  extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] window;

  always_comb begin
    // Bring the addressed byte down to lane 0; bytes beyond the size are dropped below.
    window = 32'({hi, lo} >> {off, 3'b000});
    case (funct3)
      F3_LB:   result = {{24{window[7]}}, window[7:0]};
      F3_LH:   result = {{16{window[15]}}, window[15:0]};
      F3_LW:   result = window;
      F3_LBU:  result = {24'h0, window[7:0]};
      F3_LHU:  result = {16'h0, window[15:0]};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for a word-organised data memory
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        pipeline access handshake (ready only in IDLE)
//   req_load/req_store         access type
//   req_funct3/addr/wdata      RV32I funct3, byte address, store data
//   resp_valid/fault/rdata     one-cycle completion pulse with fault flag and extended load data
//   mem_req_valid/ready        word request handshake
//   mem_we/addr/wstrb/wdata    word request fields (lane-shifted write data)
//   mem_rvalid/mem_rdata       read data return
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned SPLIT_MISALIGNED = 1,
  parameter int unsigned WORD_ADDR_W      = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_load,
  input  logic                   req_store,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic                   resp_fault,
  output logic [31:0]            resp_rdata,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_we,
  output logic [WORD_ADDR_W-1:0] mem_addr,
  output logic [3:0]             mem_wstrb,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata
);

  lsu_state_t state;

  // Captured access (valid from accept until return to IDLE)
  logic                   load_q;
  logic [2:0]             funct3_q;
  logic [1:0]             off_q;
  logic                   cross_q;
  logic [WORD_ADDR_W-1:0] word1_q;
  logic [3:0]             strb_hi_q;
  logic [31:0]            wdata_hi_q;
  logic [31:0]            lo_q;

  // Lane math on the incoming request
  logic [1:0]             in_off;
  logic [3:0]             in_mask;
  logic [7:0]             in_strb8;
  logic [31:0]            in_wdata_m;
  logic [63:0]            in_data64;
  logic                   in_cross;
  logic                   in_fault;
  logic [WORD_ADDR_W-1:0] in_word0;

  always_comb begin
    in_off     = req_addr[1:0];
    in_mask    = size_mask(req_funct3[1:0]);
    in_strb8   = {4'b0000, in_mask} << in_off;
    // Only the low bytes of wdata are significant; clear the rest so unused lanes carry zeros.
    in_wdata_m = req_wdata & {{8{in_mask[3]}}, {8{in_mask[2]}}, {8{in_mask[1]}}, {8{in_mask[0]}}};
    in_data64  = {32'h0, in_wdata_m} << {in_off, 3'b000};
    in_cross   = |in_strb8[7:4];
    in_word0   = req_addr[WORD_ADDR_W+1:2];
    in_fault   = !funct3_legal(req_load, req_store, req_funct3) ||
                 ((SPLIT_MISALIGNED == 0) && in_cross);
  end

  // Load alignment: WAIT1 combines the held low word with the arriving high word;
  // WAIT0 of an unsplit load uses the arriving word alone with hi forced to zero.
  logic [31:0] align_hi;
  logic [31:0] align_lo;
  logic [31:0] align_result;

  assign align_hi = (state == ST_WAIT1) ? mem_rdata : 32'h0;
  assign align_lo = (state == ST_WAIT1) ? lo_q : mem_rdata;

  lsu_load_align u_align (
    .hi     (align_hi),
    .lo     (align_lo),
    .off    (off_q),
    .funct3 (funct3_q),
    .result (align_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_fault    <= 1'b0;
      resp_rdata    <= 32'h0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wstrb     <= 4'h0;
      mem_wdata     <= 32'h0;
      load_q        <= 1'b0;
      funct3_q      <= 3'h0;
      off_q         <= 2'h0;
      cross_q       <= 1'b0;
      word1_q       <= '0;
      strb_hi_q     <= 4'h0;
      wdata_hi_q    <= 32'h0;
      lo_q          <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            load_q     <= req_load;
            funct3_q   <= req_funct3;
            off_q      <= in_off;
            cross_q    <= in_cross;
            word1_q    <= in_word0 + WORD_ADDR_W'(1);
            strb_hi_q  <= in_strb8[7:4];
            wdata_hi_q <= in_data64[63:32];
            req_ready  <= 1'b0;
            if (in_fault) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state         <= ST_REQ0;
              mem_req_valid <= 1'b1;
              mem_we        <= req_store;
              mem_addr      <= in_word0;
              mem_wstrb     <= req_store ? in_strb8[3:0] : 4'h0;
              mem_wdata     <= req_store ? in_data64[31:0] : 32'h0;
            end
          end
        end

        ST_REQ0, ST_REQ1: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_wstrb     <= 4'h0;
            mem_wdata     <= 32'h0;
            if (load_q) begin
              state <= (state == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
            end else if ((state == ST_REQ0) && cross_q) begin
              // Second half of a split store goes out straight away.
              state         <= ST_REQ1;
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b1;
              mem_addr      <= word1_q;
              mem_wstrb     <= strb_hi_q;
              mem_wdata     <= wdata_hi_q;
            end else begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_rdata <= 32'h0;
            end
          end
        end

        ST_WAIT0: begin
          if (mem_rvalid) begin
            lo_q <= mem_rdata;
            if (cross_q) begin
              state         <= ST_REQ1;
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b0;
              mem_addr      <= word1_q;
              mem_wstrb     <= 4'h0;
              mem_wdata     <= 32'h0;
            end else begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_rdata <= align_result;
            end
          end
        end

        ST_WAIT1: begin
          if (mem_rvalid) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= align_result;
          end
        end

        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_load, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_valid_ns, req_ready_ns, resp_valid_ns, resp_fault_ns;
  logic [31:0] resp_rdata_ns;
  logic        mem_req_valid_ns, mem_we_ns, mem_req_ready_ns, mem_rvalid_ns;
  logic [29:0] mem_addr_ns;
  logic [3:0]  mem_wstrb_ns;
  logic [31:0] mem_wdata_ns, mem_rdata_ns;

  load_store_unit #(.SPLIT_MISALIGNED(1), .WORD_ADDR_W(30)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_fault(resp_fault), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.SPLIT_MISALIGNED(0), .WORD_ADDR_W(30)) dut_ns (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_ns), .resp_fault(resp_fault_ns), .resp_rdata(resp_rdata_ns),
    .mem_req_valid(mem_req_valid_ns), .mem_req_ready(mem_req_ready_ns), .mem_we(mem_we_ns),
    .mem_addr(mem_addr_ns), .mem_wstrb(mem_wstrb_ns), .mem_wdata(mem_wdata_ns),
    .mem_rvalid(mem_rvalid_ns), .mem_rdata(mem_rdata_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory side: word store, request log, responder ----------------
  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mreq_t;

  mreq_t       mlog[$];
  logic [31:0] memw [logic [29:0]];
  logic [7:0]  refmem [logic [31:0]];

  int          stall_cnt = 0;
  int          rd_delay  = 0;
  bit          rand_mem  = 0;
  int          mreq_cycles = 0;
  bit          rd_pend = 0;
  int          rd_cnt;
  logic [29:0] rd_addr;

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    return memw.exists(w) ? memw[w] : init_word(w);
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a[31:2]) >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (refmem.exists(a)) return refmem[a];
    w = init_word(a[31:2]) >> {a[1:0], 3'b000};
    return w[7:0];
  endfunction

  task automatic preset_word(input logic [29:0] w, input logic [31:0] v);
    memw[w] = v;
    for (int i = 0; i < 4; i++) refmem[{w, 2'(i)}] = v[8*i +: 8];
  endtask

  initial begin
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(rd_addr);
          rd_pend    = 0;
        end else rd_cnt--;
      end
      if (mem_req_valid) mreq_cycles++;
      if (stall_cnt > 0) begin
        mem_req_ready = 1'b0;
        stall_cnt--;
      end else begin
        mem_req_ready = rand_mem ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      // Spurious read data while the unit is requesting or idle must be ignored.
      if (rand_mem && !rd_pend && !mem_rvalid && (mem_req_valid || req_ready) &&
          $urandom_range(0, 3) == 0)
        mem_rvalid = 1'b1;
      if (mem_req_valid && mem_req_ready && !reset) begin
        mlog.push_back('{mem_we, mem_addr, mem_wstrb, mem_wdata});
        if (mem_we) begin
          logic [31:0] w;
          w = mem_word(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_wstrb[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          memw[mem_addr] = w;
        end else begin
          rd_pend = 1;
          rd_addr = mem_addr;
          rd_cnt  = rand_mem ? int'($urandom_range(0, 2)) : rd_delay;
        end
      end
    end
  end

  // ---------------- reference model: byte-addressed memory ----------------
  task automatic ref_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] erd, output logic eflt);
    int          nb;
    logic [31:0] v;
    logic        legal;
    erd  = 32'h0;
    legal = (ld != st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                              : (f3 inside {3'd0, 3'd1, 3'd2}));
    eflt = !legal;
    if (!legal) return;
    nb = 1 << f3[1:0];
    if (st) begin
      for (int i = 0; i < nb; i++) refmem[a + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
      case (f3)
        3'd0:    erd = {{24{v[7]}}, v[7:0]};
        3'd1:    erd = {{16{v[15]}}, v[15:0]};
        default: erd = v;
      endcase
    end
  endtask

  // ---------------- pipeline-side driver ----------------
  logic [31:0] rd, erd;
  logic        flt, eflt;
  int          lat;

  task automatic lsu_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int n;
    ref_op(ld, st, f3, a, wd, erd, eflt);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_load = ld; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid  = 0;
    req_load   = 1'($urandom);
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("resp_seen", resp_valid, 1);
    rd  = resp_rdata;
    flt = resp_fault;
    chk("ready_low_in_resp", req_ready, 0);
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 0);
  endtask

  logic [31:0] lb_exp  [4] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
  logic [31:0] lbu_exp [4] = '{32'h01, 32'h7F, 32'hFF, 32'h80};
  int          snap;
  bit          bp_ok;
  logic [29:0] bp_a;
  logic [3:0]  bp_s;
  logic [31:0] bp_d;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1; req_valid = 0; req_valid_ns = 0; req_load = 0; req_store = 0;
    req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready_ns = 1; mem_rvalid_ns = 0; mem_rdata_ns = 0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_req_ready", req_ready, 1);
    reset = 0;

    // Aligned word store then load
    mlog.delete();
    lsu_op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF);
    chk("sw_latency", lat, 2);
    chk("sw_nreq", mlog.size(), 1);
    chk("sw_we", mlog[0].we, 1);
    chk("sw_addr", mlog[0].addr, 30'h40);
    chk("sw_strb", mlog[0].strb, 4'hF);
    chk("sw_data", mlog[0].wdata, 32'hDEADBEEF);
    mlog.delete();
    lsu_op(1, 0, 3'd2, 32'h100, 32'h0);
    chk("lw_latency", lat, 3);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_fault", flt, 0);
    chk("lw_read_strb", {mlog[0].we, mlog[0].strb}, 5'h00);

    // Byte/half extraction and extension
    preset_word(30'h40, 32'h80FF7F01);
    for (int i = 0; i < 4; i++) begin
      lsu_op(1, 0, 3'd0, 32'h100 + 32'(i), 32'h0);
      chk($sformatf("lb_off%0d", i), rd, lb_exp[i]);
      lsu_op(1, 0, 3'd4, 32'h100 + 32'(i), 32'h0);
      chk($sformatf("lbu_off%0d", i), rd, lbu_exp[i]);
    end
    lsu_op(1, 0, 3'd1, 32'h102, 32'h0);
    chk("lh_0x102", rd, 32'hFFFF80FF);

    // Word-crossing store and load
    mlog.delete();
    lsu_op(0, 1, 3'd2, 32'h103, 32'h11223344);
    chk("split_sw_nreq", mlog.size(), 2);
    chk("split_sw_w0", {mlog[0].addr, mlog[0].strb, mlog[0].wdata[31:24]}, {30'h40, 4'b1000, 8'h44});
    chk("split_sw_w1", {mlog[1].addr, mlog[1].strb, mlog[1].wdata}, {30'h41, 4'b0111, 32'h00112233});
    lsu_op(1, 0, 3'd2, 32'h103, 32'h0);
    chk("split_lw_rdata", rd, 32'h11223344);
    chk("split_lw_latency", lat, 5);

    // Word address wrap
    preset_word(30'h3FFFFFFF, 32'hC3123456);
    preset_word(30'h0, 32'h9876549A);
    mlog.delete();
    lsu_op(1, 0, 3'd1, 32'hFFFFFFFF, 32'h0);
    chk("wrap_rdata", rd, 32'hFFFF9AC3);
    chk("wrap_addrs", {mlog[0].addr, mlog[1].addr}, {30'h3FFFFFFF, 30'h0});

    // Faults: no memory traffic, rdata 0
    snap = mreq_cycles;
    lsu_op(1, 0, 3'd3, 32'h100, 32'h0);
    chk("flt_ld3", {flt, rd}, {1'b1, 32'h0});
    chk("flt_ld3_latency", lat, 1);
    lsu_op(0, 1, 3'd4, 32'h100, 32'h0);
    chk("flt_st4", {flt, rd}, {1'b1, 32'h0});
    lsu_op(1, 1, 3'd2, 32'h100, 32'h0);
    chk("flt_both", {flt, rd}, {1'b1, 32'h0});
    lsu_op(0, 0, 3'd2, 32'h100, 32'h0);
    chk("flt_neither", {flt, rd}, {1'b1, 32'h0});
    chk("flt_no_mem", mreq_cycles - snap, 0);

    // Non-splitting instance faults a word-crossing LW
    @(negedge clk);
    req_valid_ns = 1; req_load = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h102;
    @(negedge clk);
    req_valid_ns = 0;
    chk("ns_resp", {resp_valid_ns, resp_fault_ns, resp_rdata_ns}, {2'b11, 32'h0});
    bp_ok = 1;
    repeat (4) begin
      if (mem_req_valid_ns) bp_ok = 0;
      @(negedge clk);
    end
    chk("ns_no_mem", bp_ok, 1);

    // Backpressure: request and fields held while ready is low
    stall_cnt = 7;
    fork
      lsu_op(0, 1, 3'd2, 32'h108, 32'hCAFEF00D);
      begin
        int n;
        n = 0;
        bp_ok = 1;
        @(negedge clk);
        while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
        bp_a = mem_addr; bp_s = mem_wstrb; bp_d = mem_wdata;
        if (!mem_req_valid) bp_ok = 0;
        repeat (4) begin
          @(negedge clk);
          if (!mem_req_valid || mem_addr !== bp_a || mem_wstrb !== bp_s || mem_wdata !== bp_d)
            bp_ok = 0;
        end
        chk("bp_stable", bp_ok, 1);
      end
    join
    chk("bp_store_mem", mem_word(30'h42), 32'hCAFEF00D);

    // Reset while waiting for read data
    rd_delay = 3;
    @(negedge clk);
    req_valid = 1; req_load = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h200;
    @(negedge clk);
    req_valid = 0;
    begin
      int n;
      n = 0;
      while (mem_req_valid && n < 20) begin @(negedge clk); n++; end
    end
    chk("rst_in_wait0", {mem_req_valid, req_ready}, 2'b00);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_resp_valid", resp_valid, 0);
    bp_ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid || mem_req_valid) bp_ok = 0;
    end
    chk("rstw_late_rvalid_ignored", bp_ok, 1);
    rd_delay = 0;
    lsu_op(1, 0, 3'd2, 32'h200, 32'h0);
    chk("rstw_after_load", rd, erd);

    // Randomized accesses against the byte model
    rand_mem = 1;
    for (int i = 0; i < 300; i++) begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      int          nb;
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                       : (32'h300 + 32'($urandom_range(0, 31)));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ld = 1'($urandom); st = 1'($urandom); f3 = 3'($urandom);
      end else begin
        ld = 1'($urandom); st = !ld;
        if (ld) begin
          nb = $urandom_range(0, 4);
          f3 = (nb < 3) ? 3'(nb) : 3'(nb + 1);
        end else f3 = 3'($urandom_range(0, 2));
      end
      lsu_op(ld, st, f3, a, wd);
      chk("rnd_fault", flt, eflt);
      chk("rnd_rdata", rd, erd);
      if (st && !ld && !eflt) begin
        nb = 1 << f3[1:0];
        for (int j = 0; j < nb; j++)
          chk("rnd_mem_byte", mem_byte(a + 32'(j)), ref_byte(a + 32'(j)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
